// File: rtl/secure_register_bank.sv
// secure_register_bank: bank of thread-gated registers with per-register
// owner and write-lock, a saturating count of denied requests and a
// sticky alarm at a configurable threshold.
// Optional feature macro: SECURE_REG_LOCKOUT_EN -- when defined, a raised
// alarm denies every later request (including the privileged thread)
// until reset; when undefined the alarm is a status flag only.
module secure_register_bank #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned NUM_REGS       = 8,
  parameter int unsigned TID_WIDTH      = 4,
  parameter int unsigned PRIV_TID       = 0,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  parameter int unsigned VIOL_CNT_WIDTH = 8,
  parameter int unsigned VIOL_THRESHOLD = 4,
  localparam int unsigned ADDR_WIDTH    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      access_en,
  input  logic [1:0]                op,
  input  logic [ADDR_WIDTH-1:0]     addr,
  input  logic [TID_WIDTH-1:0]      thread_id,
  input  logic [DATA_WIDTH-1:0]     data_in,
  output logic                      resp_valid,
  output logic                      resp_err,
  output logic [DATA_WIDTH-1:0]     data_out,
  output logic [NUM_REGS-1:0]       lock_status,
  output logic [VIOL_CNT_WIDTH-1:0] viol_count,
  output logic                      alarm
);

  localparam int unsigned CMP_WIDTH = ADDR_WIDTH + 1;
  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_LOCK  = 2'b10;
  localparam logic [1:0] OP_OWNER = 2'b11;

`ifdef SECURE_REG_LOCKOUT_EN
  localparam bit LOCKOUT = 1'b1;
`else
  localparam bit LOCKOUT = 1'b0;
`endif

  logic [DATA_WIDTH-1:0] regs  [NUM_REGS];
  logic [TID_WIDTH-1:0]  owner [NUM_REGS];

  logic                  in_range_c;
  logic                  is_priv_c;
  logic                  auth_c;
  logic                  locked_c;
  logic                  grant_c;
  logic [TID_WIDTH-1:0]  owner_c;
  logic [DATA_WIDTH-1:0] rdata_c;

  // Access decision for the request presented this cycle
  always_comb begin
    in_range_c = ({1'b0, addr} < CMP_WIDTH'(NUM_REGS));
    is_priv_c  = (thread_id == TID_WIDTH'(PRIV_TID));
    owner_c    = '0;
    locked_c   = 1'b0;
    rdata_c    = '0;
    grant_c    = 1'b0;
    if (in_range_c) begin
      owner_c  = owner[addr];
      locked_c = lock_status[addr];
      rdata_c  = regs[addr];
    end
    auth_c = in_range_c && (is_priv_c || (thread_id == owner_c));
    case (op)
      OP_READ:  grant_c = auth_c;
      OP_WRITE: grant_c = auth_c && !locked_c;
      OP_LOCK:  grant_c = in_range_c && is_priv_c;
      OP_OWNER: grant_c = in_range_c && is_priv_c && !locked_c;
      default:  grant_c = 1'b0;
    endcase
    if (LOCKOUT && alarm) grant_c = 1'b0;
  end

  // Register contents, owners and lock bits
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs[i]  <= RESET_VALUE;
        owner[i] <= TID_WIDTH'(PRIV_TID);
      end
      lock_status <= '0;
    end else if (access_en && grant_c) begin
      case (op)
        OP_WRITE: regs[addr]        <= data_in;
        OP_LOCK:  lock_status[addr] <= 1'b1;
        OP_OWNER: owner[addr]       <= data_in[TID_WIDTH-1:0];
        default:  ;
      endcase
    end
  end

  // One-cycle response, violation counter and sticky alarm
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      data_out   <= '0;
      viol_count <= '0;
      alarm      <= 1'b0;
    end else begin
      resp_valid <= access_en;
      resp_err   <= access_en && !grant_c;
      data_out   <= (access_en && grant_c && (op == OP_READ)) ? rdata_c : '0;
      if (access_en && !grant_c && (viol_count != '1)) begin
        viol_count <= viol_count + VIOL_CNT_WIDTH'(1);
        if ((viol_count + VIOL_CNT_WIDTH'(1)) == VIOL_CNT_WIDTH'(VIOL_THRESHOLD))
          alarm <= 1'b1;
      end
    end
  end

endmodule

// File: doc/secure_register_bank.md
Name: secure_register_bank

Overview:
- Parametrised successor to the single thread-gated secure register: a bank of NUM_REGS registers, each with a per-register owner thread ID and a write-lock bit.
- Access is checked per request against the privileged thread and the register owner. Every denied request is counted, and a sticky alarm is raised at a threshold.
- Sits behind the core's thread-tagged register bus. Holds keys, configuration and other privileged state for the SoC security subsystem.

Parameters:
- DATA_WIDTH, 32, register and data bus width.
- NUM_REGS, 8, number of registers (2..256, need not be a power of 2).
- TID_WIDTH, 4, thread ID width.
- PRIV_TID, 0, privileged thread ID.
- RESET_VALUE, 0, reset value of every register.
- VIOL_CNT_WIDTH, 8, width of the violation counter.
- VIOL_THRESHOLD, 4, counter value at which the alarm asserts (1..2^VIOL_CNT_WIDTH-1).
- Localparam ADDR_WIDTH = max(1, clog2(NUM_REGS)).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- access_en  in  1  request strobe, one request per cycle.
- op  in  2  operation: 00 read, 01 write, 10 lock, 11 set-owner.
- addr  in  ADDR_WIDTH  register index.
- thread_id  in  TID_WIDTH  requesting thread.
- data_in  in  DATA_WIDTH  write data; for set-owner, bits [TID_WIDTH-1:0] carry the new owner.
- resp_valid  out  1  response strobe, one cycle after the request.
- resp_err  out  1  request denied; valid only with resp_valid.
- data_out  out  DATA_WIDTH  read data; valid only with resp_valid.
- lock_status  out  NUM_REGS  per-register lock bits.
- viol_count  out  VIOL_CNT_WIDTH  saturating count of denied requests.
- alarm  out  1  sticky violation alarm.

Behaviour:
- Reset (rst=1 at a clock edge):
  - regs = RESET_VALUE, owner[i] = PRIV_TID, lock_status = 0.
  - viol_count = 0, alarm = 0, resp_valid = 0, resp_err = 0, data_out = 0.
  - Reset takes priority over any request sampled in the same cycle; that request is dropped with no response.
- Authorisation:
  - auth = (thread_id == PRIV_TID) || (thread_id == owner[addr]).
  - addr >= NUM_REGS means denied for every op.
- Read: allowed if auth, lock state irrelevant. data_out = reg[addr].
- Write: allowed if auth and !lock_status[addr]. reg[addr] = data_in at the request edge.
- Lock:
  - Allowed only for PRIV_TID. Sets lock_status[addr].
  - A lock bit clears only on reset. Locking an already-locked register is allowed, with no change.
- Set-owner:
  - Allowed only for PRIV_TID and only if the register is not locked.
  - owner[addr] = data_in[TID_WIDTH-1:0].
- Response timing (fixed 1-cycle latency):
  - resp_valid pulses one cycle after each access_en; resp_err reflects the decision.
  - data_out = read data on a granted read, else 0. A denied read never leaks register contents.
  - data_out holds 0 whenever resp_valid is 0.
- Back-to-back requests are supported every cycle. A read following a write to the same addr in the next cycle returns the new data; no hazard.
- Violation counter:
  - Increments by 1 on each denied request, saturating at all-ones.
  - Granted requests never change it.
- Alarm:
  - Set in the same cycle viol_count transitions to VIOL_THRESHOLD (registered alongside the counter).
  - Sticky; clears only on reset.
- access_en=0: no state change; op, addr, thread_id and data_in are ignored.

Optional Feature:
- Macro: SECURE_REG_LOCKOUT_EN.
- Defined: once alarm=1, every subsequent request is denied, including PRIV_TID.
  - resp_err=1 and data_out=0 for each such request.
  - Denied requests still increment the saturating counter.
  - Lockout persists until reset.
- Undefined: alarm is a status flag only; access control is unaffected.

Test Plan:
- Reset, then PRIV_TID=0 writes 0xDEADBEEF to addr 3 and reads it back -> resp_valid one cycle after each request; read resp_err=0, data_out=0xDEADBEEF.
- Thread 5 reads addr 3 (owner 0) -> resp_err=1, data_out=0, viol_count=1. Then thread 0 set-owner addr 3 to 5; thread 5 reads -> resp_err=0, data_out=0xDEADBEEF.
- Thread 0 locks addr 3; thread 0 writes 0x1234 -> resp_err=1, value unchanged. Set-owner to 7 -> denied. Read still returns 0xDEADBEEF; lock_status[3]=1.
- With NUM_REGS=6, read addr 7 from thread 0 -> resp_err=1, data_out=0.
- Four denied requests, VIOL_THRESHOLD=4 -> alarm rises with viol_count=4.
  - Macro undefined: thread 0 read still succeeds.
  - Macro defined: thread 0 read is denied with data_out=0.
  - Then rst -> alarm=0, lock_status=0, regs=RESET_VALUE.
- Write issued in the same cycle as rst=1 -> no response next cycle; register reads RESET_VALUE afterwards.
